control_sequencer: RTL

Hardwired control unit that replaces hand-stepped T0…T7 control pulses with a clocked Moore state machine driving the CPU `DataPath` control inputs. It fetches an instruction, decodes the 5-bit opcode from the IR, and sequences register, ALU, memory and HI/LO transfers per instruction class. Memory read and write steps are stretched by a parametrised wait-state count. Sits beside `DataPath` at the CPU top level and shares its clock and clear.

---
 rtl/control_sequencer.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer for the DataPath: fetch, decode of ir[31:32-OPC_W], per-class execute steps.
// Latency: fetch 3+MEM_WAIT cycles; ALU 6+W, ld/st 8+2W, mul/div 7+W, nop/halt/illegal 4+W total per instruction.
// No backpressure: memory steps stretch by MEM_WAIT cycles; CTRL_SEQ_MULDIV_EN enables the mul/div sequence.
module control_sequencer #(
    parameter int OPC_W    = 5,
    parameter int MEM_WAIT = 0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic [31:0]      ir,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             Read,
    output logic             Write,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             PCin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic             Yin,
    output logic             Cout,
    output logic             HIin,
    output logic             LOin,
    output logic [OPC_W-1:0] opcode,
    output logic [3:0]       step,
    output logic             done,
    output logic             illegal,
    output logic             halted
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_RWAIT = 4'd3,
        S_T2    = 4'd4,
        S_T3    = 4'd5,
        S_T4    = 4'd6,
        S_T5    = 4'd7,
        S_T6    = 4'd8,
        S_T7    = 4'd9,
        S_WWAIT = 4'd10,
        S_HALT  = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        C_LD, C_ST, C_ALU, C_IMM, C_MD, C_NOP, C_HALT, C_ILL
    } class_e;

    // Wait counter reload value; wraps harmlessly when MEM_WAIT is 0 because the wait states are skipped.
    localparam logic [2:0] WAIT_LD = 3'(MEM_WAIT - 1);

    state_e           state_q, state_d;
    logic [2:0]       wcnt_q, wcnt_d;
    logic             rret_q, rret_d;   // RWAIT returns to T7 (ld data read) rather than T2 (fetch)
    logic             rlow_q, rlow_d;   // run seen low while halted
    class_e           cls;
    logic [OPC_W-1:0] opc_f;
    logic [OPC_W-1:0] imm_op;
    logic             unused_ir;

    assign opc_f     = ir[31 -: OPC_W];
    assign unused_ir = ^ir[31-OPC_W:0];
    assign step      = state_q;

    // Classify the IR opcode and pick the ALU operation for immediate forms.
    always_comb begin
        cls    = C_ILL;
        imm_op = '0;
        if (opc_f == OPC_W'(0))
            cls = C_LD;
        else if (opc_f == OPC_W'(2))
            cls = C_ST;
        else if (opc_f >= OPC_W'(3) && opc_f <= OPC_W'(11))
            cls = C_ALU;
        else if (opc_f == OPC_W'(12)) begin
            cls    = C_IMM;
            imm_op = OPC_W'(3);
        end else if (opc_f == OPC_W'(13)) begin
            cls    = C_IMM;
            imm_op = OPC_W'(5);
        end else if (opc_f == OPC_W'(14)) begin
            cls    = C_IMM;
            imm_op = OPC_W'(6);
        end
`ifdef CTRL_SEQ_MULDIV_EN
        else if (opc_f == OPC_W'(15) || opc_f == OPC_W'(16))
            cls = C_MD;
`endif
        else if (opc_f == OPC_W'(26))
            cls = C_NOP;
        else if (opc_f == OPC_W'(27))
            cls = C_HALT;
    end

    // State, wait counter and flags; clear aborts everything back to IDLE at once.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            wcnt_q  <= 3'd0;
            rret_q  <= 1'b0;
            rlow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rret_q  <= rret_d;
            rlow_q  <= rlow_d;
        end
    end

    // Next-state sequencing; run is looked at only in IDLE, HALT and on an instruction's final step.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rret_d  = rret_q;
        rlow_d  = rlow_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1: begin
                if (MEM_WAIT == 0) state_d = S_T2;
                else begin
                    state_d = S_RWAIT;
                    wcnt_d  = WAIT_LD;
                    rret_d  = 1'b0;
                end
            end
            S_RWAIT: begin
                if (wcnt_q == 3'd0) state_d = rret_q ? S_T7 : S_T2;
                else                wcnt_d  = wcnt_q - 3'd1;
            end
            S_T2: state_d = S_T3;
            S_T3: begin
                case (cls)
                    C_NOP, C_ILL: state_d = run ? S_T0 : S_IDLE;
                    C_HALT: begin
                        state_d = S_HALT;
                        rlow_d  = 1'b0;
                    end
                    default: state_d = S_T4;
                endcase
            end
            S_T4: state_d = S_T5;
            S_T5: begin
                if (cls == C_ALU || cls == C_IMM) state_d = run ? S_T0 : S_IDLE;
                else                              state_d = S_T6;
            end
            S_T6: begin
                if (cls == C_LD) begin
                    if (MEM_WAIT == 0) state_d = S_T7;
                    else begin
                        state_d = S_RWAIT;
                        wcnt_d  = WAIT_LD;
                        rret_d  = 1'b1;
                    end
                end else if (cls == C_ST)
                    state_d = S_T7;
                else
                    state_d = run ? S_T0 : S_IDLE;
            end
            S_T7: begin
                if (cls == C_ST && MEM_WAIT != 0) begin
                    state_d = S_WWAIT;
                    wcnt_d  = WAIT_LD;
                end else
                    state_d = run ? S_T0 : S_IDLE;
            end
            S_WWAIT: begin
                if (wcnt_q == 3'd0) state_d = run ? S_T0 : S_IDLE;
                else                wcnt_d  = wcnt_q - 3'd1;
            end
            S_HALT: begin
                if (!run)        rlow_d = 1'b1;
                else if (rlow_q) begin
                    state_d = S_T0;
                    rlow_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore strobe decode from the state register and the IR class.
    always_comb begin
        PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin = 1'b0;
        Read = 1'b0; Write = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
        PCin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; Yin = 1'b0; Cout = 1'b0; HIin = 1'b0; LOin = 1'b0;
        opcode = '0; done = 1'b0; illegal = 1'b0; halted = 1'b0;
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_RWAIT: begin Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                case (cls)
                    C_LD, C_ST:   begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    C_ALU, C_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
`ifdef CTRL_SEQ_MULDIV_EN
                    C_MD:         begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
`endif
                    C_NOP, C_HALT: done = 1'b1;
                    default:      begin illegal = 1'b1; done = 1'b1; end
                endcase
            end
            S_T4: begin
                case (cls)
                    C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; opcode = OPC_W'(3); end
                    C_ALU:      begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = opc_f; end
                    C_IMM:      begin Cout = 1'b1; Zin = 1'b1; opcode = imm_op; end
`ifdef CTRL_SEQ_MULDIV_EN
                    C_MD:       begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = opc_f; end
`endif
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_LD, C_ST:   begin Zlowout = 1'b1; MARin = 1'b1; end
                    C_ALU, C_IMM: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
`ifdef CTRL_SEQ_MULDIV_EN
                    C_MD:         begin Zlowout = 1'b1; LOin = 1'b1; end
`endif
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD: begin Read = 1'b1; MDRin = 1'b1; end
                    C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
`ifdef CTRL_SEQ_MULDIV_EN
                    C_MD: begin Zhighout = 1'b1; HIin = 1'b1; done = 1'b1; end
`endif
                    default: ;
                endcase
            end
            S_T7: begin
                if (cls == C_LD) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                end else if (cls == C_ST) begin
                    Write = 1'b1;
                    done  = (MEM_WAIT == 0);
                end
            end
            S_WWAIT: begin
                Write = 1'b1;
                done  = (wcnt_q == 3'd0);
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule
